// File: rtl/fsk_tx_frame_ctrl.sv
// Transmit-side frame sequencer for the ultrasonic FSK modem.
// Sends carrier warm-up, an alternating preamble, then start / 8 data bits
// (LSB first) / stop for each byte, and a carrier tail after the last byte.
// Bytes offered on the final stop cycle are chained with no warm-up or preamble.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | carrier off, waiting for a byte
//   S_WARM  | carrier on, data 0, GUARD_CYCLES of warm-up
//   S_PRE   | PREAMBLE_BITS alternating symbols, first symbol 1
//   S_START | one start symbol (0)
//   S_DATA  | 8 data symbols, LSB first from the shift register
//   S_STOP  | one stop symbol (1); last cycle may accept a chained byte
//   S_TAIL  | carrier on, data 1, GUARD_CYCLES of tail, then frame_done

module fsk_tx_frame_ctrl #(
   parameter int BIT_CYCLES    = 10000,
   parameter int PREAMBLE_BITS = 8,
   parameter int GUARD_CYCLES  = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       mod_enable,
   output logic       mod_data,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARM,
      S_PRE,
      S_START,
      S_DATA,
      S_STOP,
      S_TAIL
   } state_t;

   localparam logic [15:0] BIT_LOAD   = 16'(BIT_CYCLES - 1);
   localparam logic [15:0] GUARD_LOAD = 16'(GUARD_CYCLES - 1);
   localparam logic [7:0]  PRE_LAST   = 8'(PREAMBLE_BITS - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  pre_q, pre_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        en_q, en_d;
   logic        data_q, data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        cnt_zero;
   logic        accept;

   assign mod_enable = en_q;
   assign mod_data   = data_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   // Ready only when idle or on the very last cycle of a stop symbol.
   always_comb begin
      cnt_zero = (cnt_q == 16'd0);
      tx_ready = (state_q == S_IDLE) || ((state_q == S_STOP) && cnt_zero);
      accept   = tx_valid && tx_ready;
   end

   // State register and registered modulator outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         pre_q   <= 8'd0;
         bit_q   <= 4'd0;
         shift_q <= 8'd0;
         en_q    <= 1'b0;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         en_q    <= en_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state sequencing; outputs are decoded from the next state so they register in step.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_WARM;
               cnt_d   = GUARD_LOAD;
               pre_d   = 8'd0;
               bit_d   = 4'd0;
               shift_d = tx_data;
            end
         end
         S_WARM: begin
            if (cnt_zero) begin
               state_d = S_PRE;
               cnt_d   = BIT_LOAD;
               pre_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_PRE: begin
            if (cnt_zero) begin
               cnt_d = BIT_LOAD;
               if (pre_q == PRE_LAST) begin
                  state_d = S_START;
               end else begin
                  pre_d = pre_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_START: begin
            if (cnt_zero) begin
               state_d = S_DATA;
               cnt_d   = BIT_LOAD;
               bit_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_zero) begin
               cnt_d = BIT_LOAD;
               if (bit_q == 4'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_zero) begin
               if (accept) begin
                  state_d = S_START;
                  cnt_d   = BIT_LOAD;
                  shift_d = tx_data;
               end else begin
                  state_d = S_TAIL;
                  cnt_d   = GUARD_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_TAIL: begin
            if (cnt_zero) begin
               state_d = S_IDLE;
               cnt_d   = 16'd0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
      endcase

      en_d   = (state_d != S_IDLE);
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_PRE:          data_d = ~pre_d[0];
         S_DATA:         data_d = shift_d[0];
         S_STOP, S_TAIL: data_d = 1'b1;
         default:        data_d = 1'b0;
      endcase
   end

endmodule
